assert_msg_buffer: RTL and testbench
====================================

# assert_msg_buffer

Collects assertion-failure events from the runtime assertion checkers instantiated in the emulated design and drains them, in order, to the host display transactor. Sits directly downstream of the assertion checkers and upstream of the display buffer. It captures a per-event cycle timestamp so the host can print "failed at time N Cycles". It arbitrates simultaneous failures, buffers them in a FIFO, and counts events lost to backpressure.

## Interface
- `N_SRC`, 8, number of assertion sources (1..32)
- `DEPTH`, 16, FIFO entries (power of two, ≥2)
- `ARG_W`, 32, width of per-event argument (e.g. offending value of S)
- `clk`  in  1  sampling clock; every rising edge is one emulation cycle
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  capture enable; when low, `fire` is ignored
- `fire`  in  N_SRC  per-source failure strobe, one cycle per event
- `sev`  in  2*N_SRC  per-source severity (INFO=0, WARN=1, ERROR=2, FATAL=3), sampled with `fire`
- `arg`  in  ARG_W*N_SRC  per-source argument, sampled with `fire`
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  host accepts head
- `out_id`  out  5  source index of head entry
- `out_sev`  out  2  severity of head entry
- `out_arg`  out  ARG_W  argument of head entry
- `out_time`  out  64  cycle count at which head event fired
- `drop_cnt`  out  16  events lost, saturating
- `fatal_seen`  out  1  sticky: a FATAL event has been accepted into the FIFO
- `empty`  out  1  FIFO empty and no pending events

## Operation
- Cycle counter: 64-bit, 0 after reset, +1 every edge, wraps 2^64-1 → 0.
- Per-source pending slot holds {sev, arg, time}. On an edge where `enable && fire[i]`:
  - slot i free, or granted this same edge → slot loads and becomes pending (no drop);
  - slot i pending and not granted → new event discarded, `drop_cnt` +1 (saturate 0xFFFF; multiple drops in one cycle add their count, still saturating).
- Arbiter: round-robin over pending slots. The pointer starts at 0 and moves to grant+1 (mod N_SRC) after each grant. At most one grant per edge, and only when the FIFO is not full (registered count < DEPTH).
- Grant writes {id, sev, arg, time} into FIFO and frees the slot.
- Read: `out_valid && out_ready` pops the head. A write and a pop on the same edge are both performed. When full, a write is blocked even if a pop occurs that edge.
- `fatal_seen` sets on the FIFO write of a FATAL entry and clears only on reset.
- `enable` low does not flush pending slots or FIFO. Draining continues.

## Timing
- Reset values: `out_valid`=0, `out_id`/`out_sev`/`out_arg`/`out_time`=0, `drop_cnt`=0, `fatal_seen`=0, `empty`=1, counter=0, all slots free, RR pointer=0.
- Reset mid-operation discards all pending and buffered events immediately (async).
- Latency from `fire` sampled at edge t with no contention: slot pending after t, FIFO write at t+1, `out_valid` high after t+1. `out_time` equals the counter value present at edge t.
- Outputs are registered/FIFO-head. `out_*` are stable while `out_valid && !out_ready`.
- Throughput: 1 event/cycle sustained.

## Configuration
- `ASSERT_MSG_TIMESTAMP_EN` defined: the cycle counter and per-slot/FIFO time storage exist. `out_time` behaves as specified.
- Undefined: the counter and time storage are removed. `out_time` is tied to 0. All other behaviour is identical.

## Structure
- `assert_msg_pkg`: severity enum, entry struct {id, sev, arg, time}, and `DROP_W`=16.
- Sub-module `assert_msg_fifo`: synchronous FIFO, DEPTH×entry, with full/empty/count outputs, async active-low reset. Arbiter, slots, and counters live in the top level.

## Test plan
- Reset, then `fire[3]` with sev=ERROR, arg=1 at cycle 10, `out_ready`=1 → `out_valid` one cycle after the write, with id=3, sev=2, arg=1, time=10. Then `empty`=1.
- `fire` = 0xFF in one cycle, `out_ready`=1 → eight entries delivered over consecutive cycles in ids 0..7, all with the same time.
- `out_ready`=0 and 20 single-source events spaced 2 cycles apart with DEPTH=16 → 16 buffered, 1 pending, 3 dropped (`drop_cnt`=3). Release `out_ready` → 17 delivered in order.
- FATAL event on source 5 → `fatal_seen`=1 after its FIFO write, and it stays 1 after the entry drains.
- `enable`=0 while `fire`=0xFF for 4 cycles → no entries, `drop_cnt`=0, `empty`=1.
- Assert `rst_n`=0 with 8 entries buffered → `out_valid`=0 and `empty`=1 immediately. After release, the counter restarts from 0.

Source files
------------

// File: rtl/assert_msg_pkg.sv
// Shared widths, severity encoding and entry header for the assertion message buffer.
// Used by assert_msg_buffer; the ASSERT_MSG_TIMESTAMP_EN option lives in the top level.
package assert_msg_pkg;

    localparam int DROP_W = 16;
    localparam int ID_W   = 5;
    localparam int TIME_W = 64;

    typedef enum logic [1:0] {
        SEV_INFO  = 2'd0,
        SEV_WARN  = 2'd1,
        SEV_ERROR = 2'd2,
        SEV_FATAL = 2'd3
    } sev_e;

    // Fields every buffered entry carries; argument and timestamp widths are chosen by the top.
    typedef struct packed {
        logic [ID_W-1:0] id;
        sev_e            sev;
    } entry_hdr_t;

    // Add this cycle's drop count to the running total, pinning at all-ones.
    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] cur,
                                                       input logic [ID_W:0]     inc);
        logic [DROP_W:0] sum;
        sum = {1'b0, cur} + (DROP_W+1)'(inc);
        return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/assert_msg_fifo.sv
// Synchronous first-word-fall-through FIFO of DEPTH x W bits with full/empty/count.
// A write on a full FIFO is ignored even if a read happens on the same edge.
module assert_msg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_ok, rd_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves one unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count and pointers decide validity, so stale words are never read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/assert_msg_buffer.sv
// Collects assertion-failure events into per-source slots, arbitrates round-robin into a FIFO.
// Define ASSERT_MSG_TIMESTAMP_EN to add the 64-bit cycle counter and per-event timestamps.
module assert_msg_buffer
    import assert_msg_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int DEPTH = 16,
    parameter int ARG_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [N_SRC-1:0]       fire,
    input  logic [2*N_SRC-1:0]     sev,
    input  logic [ARG_W*N_SRC-1:0] arg,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [1:0]             out_sev,
    output logic [ARG_W-1:0]       out_arg,
    output logic [TIME_W-1:0]      out_time,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   fatal_seen,
    output logic                   empty
);
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        entry_hdr_t        hdr;
        logic [ARG_W-1:0]  arg;
`ifdef ASSERT_MSG_TIMESTAMP_EN
        logic [TIME_W-1:0] stamp;
`endif
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic [N_SRC-1:0]  pend_q, pend_d;
    sev_e              slot_sev_q [N_SRC];
    sev_e              slot_sev_d [N_SRC];
    logic [ARG_W-1:0]  slot_arg_q [N_SRC];
    logic [ARG_W-1:0]  slot_arg_d [N_SRC];
`ifdef ASSERT_MSG_TIMESTAMP_EN
    logic [TIME_W-1:0] slot_time_q [N_SRC];
    logic [TIME_W-1:0] slot_time_d [N_SRC];
    logic [TIME_W-1:0] cyc_q, cyc_d;
`endif
    logic [ID_W-1:0]   rr_q, rr_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              fatal_q, fatal_d;

    logic              gnt_valid;
    logic [ID_W-1:0]   gnt_idx;
    logic [SEL_W-1:0]  gnt_sel;
    logic [ID_W:0]     drop_inc;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_rd_data;
    entry_t            wr_entry, head;
    logic              pop;

    // Round-robin: scan downward so the last hit is the first pending slot at or after rr_q.
    always_comb begin
        int idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (pend_q[idx[SEL_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
        if (fifo_full) gnt_valid = 1'b0;
    end

    assign gnt_sel = SEL_W'(gnt_idx);

    // A slot granted this edge is free again, so a same-edge fire reloads it without a drop.
    always_comb begin
        logic granted;
        pend_d      = pend_q;
        slot_sev_d  = slot_sev_q;
        slot_arg_d  = slot_arg_q;
`ifdef ASSERT_MSG_TIMESTAMP_EN
        slot_time_d = slot_time_q;
`endif
        drop_inc    = '0;
        granted     = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            granted = gnt_valid && (gnt_idx == ID_W'(i));
            if (granted) pend_d[i] = 1'b0;
            if (enable && fire[i]) begin
                if (!pend_q[i] || granted) begin
                    pend_d[i]      = 1'b1;
                    slot_sev_d[i]  = sev_e'(sev[2*i +: 2]);
                    slot_arg_d[i]  = arg[ARG_W*i +: ARG_W];
`ifdef ASSERT_MSG_TIMESTAMP_EN
                    slot_time_d[i] = cyc_q;
`endif
                end else begin
                    drop_inc = drop_inc + (ID_W+1)'(1);
                end
            end
        end
    end

    always_comb begin
        wr_entry         = '0;
        wr_entry.hdr.id  = gnt_idx;
        wr_entry.hdr.sev = slot_sev_q[gnt_sel];
        wr_entry.arg     = slot_arg_q[gnt_sel];
`ifdef ASSERT_MSG_TIMESTAMP_EN
        wr_entry.stamp   = slot_time_q[gnt_sel];
`endif
    end

    always_comb begin
        rr_d    = rr_q;
        if (gnt_valid) rr_d = (gnt_idx == ID_W'(N_SRC - 1)) ? '0 : gnt_idx + ID_W'(1);
        drop_d  = sat_add_drop(drop_q, drop_inc);
        fatal_d = fatal_q || (gnt_valid && (slot_sev_q[gnt_sel] == SEV_FATAL));
`ifdef ASSERT_MSG_TIMESTAMP_EN
        cyc_d   = cyc_q + TIME_W'(1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            rr_q    <= '0;
            drop_q  <= '0;
            fatal_q <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                slot_sev_q[i]  <= SEV_INFO;
                slot_arg_q[i]  <= '0;
`ifdef ASSERT_MSG_TIMESTAMP_EN
                slot_time_q[i] <= '0;
`endif
            end
`ifdef ASSERT_MSG_TIMESTAMP_EN
            cyc_q   <= '0;
`endif
        end else begin
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            drop_q      <= drop_d;
            fatal_q     <= fatal_d;
            slot_sev_q  <= slot_sev_d;
            slot_arg_q  <= slot_arg_d;
`ifdef ASSERT_MSG_TIMESTAMP_EN
            slot_time_q <= slot_time_d;
            cyc_q       <= cyc_d;
`endif
        end
    end

    assert_msg_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (gnt_valid),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head       = entry_t'(fifo_rd_data);
    assign out_valid  = (fifo_count != '0);
    assign pop        = out_valid && out_ready;
    assign empty      = fifo_empty && !(|pend_q);
    assign drop_cnt   = drop_q;
    assign fatal_seen = fatal_q;

    // Head fields read as zero when nothing is buffered, matching their reset values.
    assign out_id  = out_valid ? head.hdr.id  : '0;
    assign out_sev = out_valid ? head.hdr.sev : 2'b00;
    assign out_arg = out_valid ? head.arg     : '0;
`ifdef ASSERT_MSG_TIMESTAMP_EN
    assign out_time = out_valid ? head.stamp : '0;
`else
    assign out_time = '0;
`endif

endmodule

// File: tb/tb_assert_msg_buffer.sv
// Self-checking bench for assert_msg_buffer: queue-based reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic phases.
module tb_assert_msg_buffer;

    localparam int N_SRC = 8;
    localparam int DEPTH = 16;
    localparam int ARG_W = 32;
`ifdef ASSERT_MSG_TIMESTAMP_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   enable = 1'b1;
    logic [N_SRC-1:0]       fire = '0;
    logic [2*N_SRC-1:0]     sev = '0;
    logic [ARG_W*N_SRC-1:0] arg = '0;
    logic                   out_ready = 1'b0;
    logic                   out_valid;
    logic [4:0]             out_id;
    logic [1:0]             out_sev;
    logic [ARG_W-1:0]       out_arg;
    logic [63:0]            out_time;
    logic [15:0]            drop_cnt;
    logic                   fatal_seen;
    logic                   empty;

    assert_msg_buffer #(.N_SRC(N_SRC), .DEPTH(DEPTH), .ARG_W(ARG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fire       (fire),
        .sev        (sev),
        .arg        (arg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_sev    (out_sev),
        .out_arg    (out_arg),
        .out_time   (out_time),
        .drop_cnt   (drop_cnt),
        .fatal_seen (fatal_seen),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        else pass_cnt++;
    endtask

    // Reference model: pending events per source, the buffered stream as a queue.
    typedef struct {
        logic [4:0]       id;
        logic [1:0]       sev;
        logic [ARG_W-1:0] arg;
        logic [63:0]      t;
    } ment_t;

    ment_t            m_q[$];
    bit               m_pend [N_SRC];
    logic [1:0]       m_sev  [N_SRC];
    logic [ARG_W-1:0] m_arg  [N_SRC];
    logic [63:0]      m_time [N_SRC];
    int               m_rr    = 0;
    int               m_drop  = 0;
    bit               m_fatal = 1'b0;
    logic [63:0]      m_cyc   = '0;

    initial begin : model
        int    g;
        bit    do_pop;
        ment_t e;
        for (int i = 0; i < N_SRC; i++) m_pend[i] = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                for (int i = 0; i < N_SRC; i++) m_pend[i] = 1'b0;
                m_rr = 0; m_drop = 0; m_fatal = 1'b0; m_cyc = '0;
            end else begin
                do_pop = (m_q.size() > 0) && out_ready;
                g = -1;
                if (m_q.size() < DEPTH)
                    for (int k = 0; k < N_SRC; k++)
                        if (g < 0 && m_pend[(m_rr + k) % N_SRC]) g = (m_rr + k) % N_SRC;
                if (do_pop) void'(m_q.pop_front());
                if (g >= 0) begin
                    e.id = 5'(g); e.sev = m_sev[g]; e.arg = m_arg[g]; e.t = m_time[g];
                    m_q.push_back(e);
                    m_pend[g] = 1'b0;
                    m_rr = (g + 1) % N_SRC;
                    if (e.sev == 2'd3) m_fatal = 1'b1;
                end
                if (enable)
                    for (int i = 0; i < N_SRC; i++)
                        if (fire[i]) begin
                            if (m_pend[i]) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
                            else begin
                                m_pend[i] = 1'b1;
                                m_sev[i]  = sev[2*i +: 2];
                                m_arg[i]  = arg[ARG_W*i +: ARG_W];
                                m_time[i] = m_cyc;
                            end
                        end
                m_cyc = m_cyc + 64'd1;
            end
        end
    end

    initial begin : compare
        bit    any_pend;
        bit    ev;
        ment_t h;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                any_pend = 1'b0;
                for (int i = 0; i < N_SRC; i++) any_pend |= m_pend[i];
                ev = (m_q.size() > 0);
                h  = '{default: '0};
                if (ev) h = m_q[0];
                check("out_valid", 64'(out_valid), 64'(ev));
                check("empty", 64'(empty), 64'(!ev && !any_pend));
                check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
                check("fatal_seen", 64'(fatal_seen), 64'(m_fatal));
                check("out_id", 64'(out_id), 64'(h.id));
                check("out_sev", 64'(out_sev), 64'(h.sev));
                check("out_arg", 64'(out_arg), 64'(h.arg));
                check("out_time", out_time, TS ? h.t : 64'd0);
            end
        end
    end

    task automatic idle_inputs();
        fire = '0; enable = 1'b1; out_ready = 1'b0;
    endtask

    // Leaves the bench just after a negedge; the next rising edge is cycle 0.
    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fire_one(input int src, input logic [1:0] s, input logic [ARG_W-1:0] a);
        fire = '0;
        fire[src] = 1'b1;
        sev[2*src +: 2] = s;
        arg[ARG_W*src +: ARG_W] = a;
    endtask

    task automatic rand_inputs(input int pct, input int rdy_pct);
        for (int i = 0; i < N_SRC; i++) begin
            fire[i] = ($urandom_range(0, 99) < pct);
            sev[2*i +: 2] = 2'($urandom_range(0, 3));
            arg[ARG_W*i +: ARG_W] = $urandom;
        end
        enable    = ($urandom_range(0, 9) != 0);
        out_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    initial begin : stim
        int got;
        int pct [4];
        int rdy [4];
        pct = '{5, 50, 30, 15};
        rdy = '{80, 90, 20, 50};

        // Reset state.
        @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst empty", 64'(empty), 64'd1);
        check("rst drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst fatal_seen", 64'(fatal_seen), 64'd0);
        check("rst out_time", out_time, 64'd0);
        cmp_en = 1'b1;

        // Single ERROR event from source 3 at cycle 10.
        do_reset();
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        fire_one(3, 2'd2, 32'd1);
        @(negedge clk);
        fire = '0;
        check("t1 pending valid", 64'(out_valid), 64'd0);
        check("t1 pending empty", 64'(empty), 64'd0);
        @(negedge clk);
        check("t1 valid", 64'(out_valid), 64'd1);
        check("t1 id", 64'(out_id), 64'd3);
        check("t1 sev", 64'(out_sev), 64'd2);
        check("t1 arg", 64'(out_arg), 64'd1);
        check("t1 time", out_time, TS ? 64'd10 : 64'd0);
        @(negedge clk);
        check("t1 drained empty", 64'(empty), 64'd1);

        // All eight sources fire together at cycle 2.
        do_reset();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N_SRC; i++) begin
            sev[2*i +: 2] = 2'(i);
            arg[ARG_W*i +: ARG_W] = 32'(100 + i);
        end
        fire = 8'hFF;
        @(negedge clk);
        fire = '0;
        for (int k = 0; k < N_SRC; k++) begin
            @(negedge clk);
            check("t2 valid", 64'(out_valid), 64'd1);
            check("t2 id", 64'(out_id), 64'(k));
            check("t2 arg", 64'(out_arg), 64'(100 + k));
            check("t2 time", out_time, TS ? 64'd2 : 64'd0);
        end

        // Backpressure: 20 events from source 2, two cycles apart, host stalled.
        do_reset();
        for (int e = 0; e < 20; e++) begin
            fire_one(2, 2'd1, 32'(e));
            @(negedge clk);
            fire = '0;
            @(negedge clk);
        end
        check("t3 drop_cnt", 64'(drop_cnt), 64'd3);
        check("t3 valid", 64'(out_valid), 64'd1);
        check("t3 empty", 64'(empty), 64'd0);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin
                check("t3 order arg", 64'(out_arg), 64'(got));
                got++;
            end
            @(negedge clk);
        end
        check("t3 delivered", 64'(got), 64'd17);
        check("t3 final empty", 64'(empty), 64'd1);

        // FATAL from source 5 sets the sticky flag on its FIFO write.
        do_reset();
        fire_one(5, 2'd3, 32'hDEAD);
        @(negedge clk);
        fire = '0;
        check("t4 fatal before write", 64'(fatal_seen), 64'd0);
        @(negedge clk);
        check("t4 fatal after write", 64'(fatal_seen), 64'd1);
        check("t4 id", 64'(out_id), 64'd5);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4 drained empty", 64'(empty), 64'd1);
        check("t4 fatal sticky", 64'(fatal_seen), 64'd1);

        // Capture disabled: nothing enters, nothing is dropped.
        do_reset();
        enable = 1'b0;
        fire   = 8'hFF;
        repeat (4) @(negedge clk);
        fire   = '0;
        enable = 1'b1;
        @(negedge clk);
        check("t5 empty", 64'(empty), 64'd1);
        check("t5 drop_cnt", 64'(drop_cnt), 64'd0);
        check("t5 valid", 64'(out_valid), 64'd0);

        // Asynchronous reset with eight entries buffered.
        do_reset();
        fire = 8'hFF;
        @(negedge clk);
        fire = '0;
        repeat (10) @(negedge clk);
        check("t6 buffered valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async valid", 64'(out_valid), 64'd0);
        check("t6 async empty", 64'(empty), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        fire_one(1, 2'd0, 32'h55);
        @(negedge clk);
        fire = '0;
        @(negedge clk);
        check("t6 restart id", 64'(out_id), 64'd1);
        check("t6 restart time", out_time, 64'd0);

        // Randomized traffic phases.
        for (int ph = 0; ph < 4; ph++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                rand_inputs(pct[ph], rdy[ph]);
                if (ph == 3 && c == 300) begin
                    #2 rst_n = 1'b0;
                    #2 rst_n = 1'b1;
                end
                @(negedge clk);
            end
            idle_inputs();
            out_ready = 1'b1;
            repeat (40) @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
